gam_recall_controller: RTL and testbench

Recall-side counterpart of the memory layer learning controller. In RECALL mode it accepts one input vector through the READY/WAIT handshake. It then reads every stored node of the memory layer back through a 1-cycle-latency read port and computes the L1 distance from the input to each node's weight vector. It reports the class, distance and threshold hit of the nearest node.

---
 rtl/gam_recall_controller.sv | 205 ++++++++++++++++++++
 tb/tb_gam_recall_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gam_recall_controller.sv
// Recall controller: scans stored nodes through a 1-cycle read port and reports the nearest node by L1 distance.
// Optional: define GAM_THRESHOLD_CHECK_EN to judge hit against the winning node's stored threshold.
package gam_recall_pkg;
  typedef enum logic {LEARNING = 1'b0, RECALL = 1'b1} LEARNING_RECALL_T;
  typedef enum logic {WAIT = 1'b0, READY = 1'b1} READY_WAIT_T;
endpackage

module gam_recall_controller
  import gam_recall_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int DW    = 8,
  parameter int NODES = 16,
  parameter int CW    = 4,
  parameter int THW   = 12,
  localparam int NW    = $clog2(NODES),
  localparam int DISTW = DW + $clog2(DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  LEARNING_RECALL_T      learning_recall,
  input  logic                  start,
  input  logic [DIM*DW-1:0]     x_in,
  input  logic [NW:0]           node_count,
  output logic                  mem_rd,
  output logic [NW-1:0]         mem_addr,
  input  logic [DIM*DW-1:0]     mem_w,
  input  logic [CW-1:0]         mem_c,
  input  logic [THW-1:0]        mem_t,
  output READY_WAIT_T           ready_wait,
  output logic                  done,
  output logic [CW-1:0]         class_out,
  output logic [DISTW-1:0]      dist_out,
  output logic                  hit,
  output logic [2:0]            state_dbg
);

  // Handshake: ready_wait==READY means the next cycle with start=1 accepts x_in
  // and node_count; ready_wait returns to WAIT the cycle after acceptance.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  state_t               state_q;
  logic [DIM*DW-1:0]    x_q;
  logic [NW:0]          cnt_q;
  logic [NW-1:0]        addr_q;
  logic                 rd_q;
  logic                 cmp_v_q;
  logic [DISTW-1:0]     min_dist_q;
  logic [CW-1:0]        min_class_q;
  READY_WAIT_T          rw_q;
  logic                 done_q;
  logic [CW-1:0]        class_q;
  logic [DISTW-1:0]     dist_q;
  logic                 hit_q;

  logic [DISTW-1:0]     dist_d;
  logic                 better_d;
  logic [DISTW-1:0]     nxt_dist_d;
  logic [CW-1:0]        nxt_class_d;
  logic                 nxt_hit_d;
  logic                 last_rd_d;
  logic                 abort_d;

`ifdef GAM_THRESHOLD_CHECK_EN
  logic [THW-1:0]       min_thr_q;
  logic [THW-1:0]       nxt_thr_d;
`else
  logic                 unused_thr;
  assign unused_thr = ^mem_t;
`endif

  function automatic logic [DISTW-1:0] l1_dist(input logic [DIM*DW-1:0] a,
                                               input logic [DIM*DW-1:0] b);
    logic [DISTW-1:0] s;
    logic [DW-1:0]    p;
    logic [DW-1:0]    q;
    s = '0;
    for (int k = 0; k < DIM; k++) begin
      p = a[k*DW +: DW];
      q = b[k*DW +: DW];
      s = s + DISTW'((p > q) ? (p - q) : (q - p));
    end
    return s;
  endfunction

  always_comb begin
    dist_d      = l1_dist(x_q, mem_w);
    // Strict less-than keeps the earliest (lowest address) node on ties.
    better_d    = cmp_v_q && (dist_d < min_dist_q);
    nxt_dist_d  = better_d ? dist_d : min_dist_q;
    nxt_class_d = better_d ? mem_c : min_class_q;
`ifdef GAM_THRESHOLD_CHECK_EN
    nxt_thr_d   = better_d ? mem_t : min_thr_q;
    nxt_hit_d   = ({{THW{1'b0}}, nxt_dist_d} <= {{DISTW{1'b0}}, nxt_thr_d});
`else
    // Only consumed on the DRAIN path, which is reached only with N != 0.
    nxt_hit_d   = 1'b1;
`endif
    last_rd_d   = (({1'b0, addr_q} + (NW+1)'(1)) == cnt_q);
    abort_d     = (learning_recall != RECALL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      cmp_v_q     <= 1'b0;
      min_dist_q  <= '1;
      min_class_q <= '0;
`ifdef GAM_THRESHOLD_CHECK_EN
      min_thr_q   <= '1;
`endif
      rw_q        <= WAIT;
      done_q      <= 1'b0;
      class_q     <= '0;
      dist_q      <= '0;
      hit_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      cmp_v_q <= rd_q;
      if (better_d) begin
        min_dist_q  <= nxt_dist_d;
        min_class_q <= nxt_class_d;
`ifdef GAM_THRESHOLD_CHECK_EN
        min_thr_q   <= nxt_thr_d;
`endif
      end
      case (state_q)
        ST_IDLE: begin
          if (!abort_d) begin
            state_q <= ST_READY;
            rw_q    <= READY;
          end
        end
        ST_READY: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            rw_q    <= WAIT;
          end else if (start) begin
            x_q         <= x_in;
            cnt_q       <= node_count;
            min_dist_q  <= '1;
            min_class_q <= '0;
            rw_q        <= WAIT;
            if (node_count == '0) begin
              state_q <= ST_RESULT;
              done_q  <= 1'b1;
              class_q <= '0;
              dist_q  <= '1;
              hit_q   <= 1'b0;
            end else begin
              state_q <= ST_SCAN;
              rd_q    <= 1'b1;
              addr_q  <= '0;
            end
          end
        end
        ST_SCAN: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            cmp_v_q <= 1'b0;
          end else if (last_rd_d) begin
            state_q <= ST_DRAIN;
            rd_q    <= 1'b0;
          end else begin
            addr_q <= addr_q + NW'(1);
          end
        end
        ST_DRAIN: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            cmp_v_q <= 1'b0;
          end else begin
            state_q <= ST_RESULT;
            done_q  <= 1'b1;
            class_q <= nxt_class_d;
            dist_q  <= nxt_dist_d;
            hit_q   <= nxt_hit_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd     = rd_q;
  assign mem_addr   = addr_q;
  assign ready_wait = rw_q;
  assign done       = done_q;
  assign class_out  = class_q;
  assign dist_out   = dist_q;
  assign hit        = hit_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_gam_recall_controller.sv
// Directed bench for gam_recall_controller: node memory model, cycle-accurate done timing, abort and reset cases.
module tb_gam_recall_controller;
  import gam_recall_pkg::*;

  logic             clk;
  logic             reset;
  LEARNING_RECALL_T learning_recall;
  logic             start;
  logic [31:0]      x_in;
  logic [4:0]       node_count;
  logic             mem_rd;
  logic [3:0]       mem_addr;
  logic [31:0]      mem_w;
  logic [3:0]       mem_c;
  logic [11:0]      mem_t;
  READY_WAIT_T      ready_wait;
  logic             done;
  logic [3:0]       class_out;
  logic [9:0]       dist_out;
  logic             hit;
  logic [2:0]       state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] w_mem[16];
  logic [3:0]  c_mem[16];
  logic [11:0] t_mem[16];
  logic [3:0]  addr_log[$];
  logic [3:0]  exp_q[$];

  gam_recall_controller dut (
    .clk(clk), .reset(reset), .learning_recall(learning_recall), .start(start),
    .x_in(x_in), .node_count(node_count), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_w(mem_w), .mem_c(mem_c), .mem_t(mem_t), .ready_wait(ready_wait),
    .done(done), .class_out(class_out), .dist_out(dist_out), .hit(hit),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // node memory with 1-cycle read latency
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_w <= w_mem[mem_addr];
      mem_c <= c_mem[mem_addr];
      mem_t <= t_mem[mem_addr];
    end
  end

  always @(negedge clk) if (mem_rd) addr_log.push_back(mem_addr);

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) begin
      w_mem[i] = pack4(200, 200, 200, 200); c_mem[i] = 4'd0; t_mem[i] = 12'd5;
    end
    w_mem[0] = pack4(0, 0, 0, 0);      c_mem[0] = 4'd1;
    w_mem[1] = pack4(9, 11, 10, 10);   c_mem[1] = 4'd2;
    w_mem[2] = pack4(20, 20, 20, 20);  c_mem[2] = 4'd3;
  endtask

  // Waits for READY, presents start in cycle 0, returns just after the cycle-1 edge.
  task automatic start_vector(input logic [4:0] n, input logic [31:0] xv);
    bit ok = 0;
    learning_recall = RECALL;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_wait == READY) begin ok = 1; break; end
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL ready_timeout: ready_wait=%0d required=%0d", ready_wait, READY);
    end
    addr_log.delete();
    x_in = xv; node_count = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vector(input logic [4:0] n, input logic [31:0] xv, output int dc,
                            output logic [3:0] cls, output logic [9:0] dst, output logic h);
    dc = -1; cls = 'x; dst = 'x; h = 1'bx;
    start_vector(n, xv);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin dc = c; cls = class_out; dst = dist_out; h = hit; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    tests_run++; if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d exp 0", state_dbg); end
    tests_run++; if (ready_wait !== WAIT) begin tests_failed++; $display("FAIL rst_ready_wait: got %0d exp 0", ready_wait); end
    tests_run++; if (mem_rd !== 1'b0 || mem_addr !== 4'd0) begin tests_failed++; $display("FAIL rst_mem: rd=%0b addr=%0d exp 0/0", mem_rd, mem_addr); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %0b exp 0", done); end
    tests_run++; if (class_out !== 4'd0 || dist_out !== 10'd0 || hit !== 1'b0) begin
      tests_failed++; $display("FAIL rst_outputs: class=%0d dist=%0d hit=%0b exp 0/0/0", class_out, dist_out, hit); end
  endtask

  task automatic test_empty();
    int dc; logic [3:0] cls; logic [9:0] dst; logic h;
    run_vector(5'd0, pack4(1, 2, 3, 4), dc, cls, dst, h);
    tests_run++; if (dc !== 1) begin tests_failed++; $display("FAIL empty_done_cycle: got %0d exp 1", dc); end
    tests_run++; if (cls !== 4'd0 || dst !== 10'h3FF || h !== 1'b0) begin
      tests_failed++; $display("FAIL empty_result: class=%0d dist=%0d hit=%0b exp 0/1023/0", cls, dst, h); end
    tests_run++; if (addr_log.size() !== 0) begin tests_failed++; $display("FAIL empty_no_reads: got %0d reads exp 0", addr_log.size()); end
  endtask

  task automatic test_basic();
    int dc; logic [3:0] cls; logic [9:0] dst; logic h;
    load_basic();
    run_vector(5'd3, pack4(10, 10, 10, 10), dc, cls, dst, h);
    tests_run++; if (dc !== 5) begin tests_failed++; $display("FAIL basic_done_cycle: got %0d exp 5", dc); end
    tests_run++; if (cls !== 4'd2) begin tests_failed++; $display("FAIL basic_class: got %0d exp 2", cls); end
    tests_run++; if (dst !== 10'd2) begin tests_failed++; $display("FAIL basic_dist: got %0d exp 2", dst); end
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("FAIL basic_hit: got %0b exp 1", h); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %0b exp 0", done); end
    exp_q = '{4'd0, 4'd1, 4'd2};
    tests_run++; if (addr_log.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL basic_addr_count: got %0d exp %0d", addr_log.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (addr_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL basic_addr[%0d]: got %0d exp %0d", i, addr_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_threshold();
    int dc; logic [3:0] cls; logic [9:0] dst; logic h; logic exp_h;
    load_basic();
    t_mem[1] = 12'd1;
`ifdef GAM_THRESHOLD_CHECK_EN
    exp_h = 1'b0;
`else
    exp_h = 1'b1;
`endif
    run_vector(5'd3, pack4(10, 10, 10, 10), dc, cls, dst, h);
    tests_run++; if (cls !== 4'd2 || dst !== 10'd2) begin tests_failed++; $display("FAIL thr_result: class=%0d dist=%0d exp 2/2", cls, dst); end
    tests_run++; if (h !== exp_h) begin tests_failed++; $display("FAIL thr_hit: got %0b exp %0b", h, exp_h); end
  endtask

  task automatic test_tie();
    int dc; logic [3:0] cls; logic [9:0] dst; logic h;
    load_basic();
    w_mem[0] = pack4(17, 10, 10, 10); c_mem[0] = 4'd5; t_mem[0] = 12'd7;
    w_mem[1] = pack4(30, 10, 10, 10); c_mem[1] = 4'd6;
    w_mem[2] = pack4(0, 0, 0, 0);     c_mem[2] = 4'd7;
    w_mem[3] = pack4(10, 10, 10, 30); c_mem[3] = 4'd8;
    w_mem[4] = pack4(10, 3, 10, 10);  c_mem[4] = 4'd9; t_mem[4] = 12'd0;
    w_mem[5] = pack4(10, 10, 10, 25); c_mem[5] = 4'd10;
    run_vector(5'd6, pack4(10, 10, 10, 10), dc, cls, dst, h);
    tests_run++; if (dc !== 8) begin tests_failed++; $display("FAIL tie_done_cycle: got %0d exp 8", dc); end
    tests_run++; if (cls !== 4'd5 || dst !== 10'd7) begin tests_failed++; $display("FAIL tie_result: class=%0d dist=%0d exp 5/7", cls, dst); end
    tests_run++; if (h !== 1'b1) begin tests_failed++; $display("FAIL tie_hit_equal_thr: got %0b exp 1", h); end
  endtask

  task automatic test_back_to_back();
    int dc; logic [3:0] cls; logic [9:0] dst; logic h;
    load_basic();
    run_vector(5'd3, pack4(10, 10, 10, 10), dc, cls, dst, h);
    tests_run++; if (cls !== 4'd2 || dst !== 10'd2) begin tests_failed++; $display("FAIL b2b_first: class=%0d dist=%0d exp 2/2", cls, dst); end
    run_vector(5'd3, pack4(20, 20, 20, 20), dc, cls, dst, h);
    tests_run++; if (dc !== 5 || cls !== 4'd3 || dst !== 10'd0 || h !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_second: cyc=%0d class=%0d dist=%0d hit=%0b exp 5/3/0/1", dc, cls, dst, h); end
  endtask

  task automatic test_full();
    int dc; logic [3:0] cls; logic [9:0] dst; logic h;
    for (int i = 0; i < 15; i++) begin
      w_mem[i] = pack4(255, 255, 255, 255); c_mem[i] = 4'd1; t_mem[i] = 12'd5;
    end
    w_mem[15] = pack4(0, 0, 0, 0); c_mem[15] = 4'hC; t_mem[15] = 12'd5;
    run_vector(5'd16, pack4(0, 0, 0, 0), dc, cls, dst, h);
    tests_run++; if (dc !== 18) begin tests_failed++; $display("FAIL full_done_cycle: got %0d exp 18", dc); end
    tests_run++; if (cls !== 4'hC || dst !== 10'd0 || h !== 1'b1) begin
      tests_failed++; $display("FAIL full_result: class=%0d dist=%0d hit=%0b exp 12/0/1", cls, dst, h); end
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    tests_run++; if (addr_log.size() !== 16) begin tests_failed++; $display("FAIL full_addr_count: got %0d exp 16", addr_log.size()); end
    else for (int i = 0; i < 16; i++) begin
      tests_run++; if (addr_log[i] !== exp_q[i]) begin tests_failed++; $display("FAIL full_addr[%0d]: got %0d exp %0d", i, addr_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    bit seen = 0;
    start_vector(5'd8, pack4(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 learning_recall = LEARNING;
    repeat (20) begin @(negedge clk); if (done) seen = 1; end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done: got %0b exp 0", seen); end
    tests_run++; if (state_dbg !== 3'd0 || ready_wait !== WAIT || mem_rd !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle: state=%0d rw=%0d rd=%0b exp 0/0/0", state_dbg, ready_wait, mem_rd); end
    tests_run++; if (class_out !== 4'hC || dist_out !== 10'd0 || hit !== 1'b1) begin
      tests_failed++; $display("FAIL abort_retained: class=%0d dist=%0d hit=%0b exp 12/0/1", class_out, dist_out, hit); end
  endtask

  task automatic test_ignored_start();
    bit seen = 0; bit rdy = 0;
    learning_recall = LEARNING;
    start = 1'b1; x_in = 32'd0; node_count = 5'd0;
    repeat (6) begin @(negedge clk); if (done) seen = 1; if (ready_wait == READY) rdy = 1; end
    start = 1'b0;
    tests_run++; if (seen !== 1'b0 || rdy !== 1'b0) begin
      tests_failed++; $display("FAIL ignored_start: done_seen=%0b ready_seen=%0b exp 0/0", seen, rdy); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    start_vector(5'd8, pack4(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++; if (state_dbg !== 3'd0 || mem_rd !== 1'b0 || done !== 1'b0 || ready_wait !== WAIT) begin
      tests_failed++; $display("FAIL rstmid_ctrl: state=%0d rd=%0b done=%0b rw=%0d exp 0/0/0/0", state_dbg, mem_rd, done, ready_wait); end
    tests_run++; if (class_out !== 4'd0 || dist_out !== 10'd0 || hit !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_outputs: class=%0d dist=%0d hit=%0b exp 0/0/0", class_out, dist_out, hit); end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) begin @(negedge clk); if (done) seen = 1; end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0b exp 0", seen); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; learning_recall = LEARNING;
    x_in = '0; node_count = '0;
    mem_w = '0; mem_c = '0; mem_t = '0;
    load_basic();
    test_reset();
    test_empty();
    test_basic();
    test_threshold();
    test_tie();
    test_back_to_back();
    test_full();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
